// File: rtl/edge_arb_pkg.sv
// Shared types, defaults and round-robin helper for the edge event arbiter.
// Optional per-channel drop counters are enabled with EDGE_ARB_DROP_CNT_EN.
package edge_arb_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [$clog2(N_CH_DEF)-1:0] ch_idx_t;

    // Pointer to the channel after ptr, wrapping at n_ch.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n_ch);
        return (ptr + 1 >= n_ch) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/edge_arb_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after rr_ptr, with wrap.
// Part of edge_event_arbiter (optional EDGE_ARB_DROP_CNT_EN has no effect here).
module edge_arb_rr_pick
    import edge_arb_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N_CH-1:0] rot;
    logic [IDX_W:0]  sum;

    always_comb begin
        // Rotate so that bit 0 is the channel rr_ptr points at.
        rot   = N_CH'({pending, pending} >> rr_ptr);
        found = 1'b0;
        sum   = '0;
        // Descending scan so the lowest rotated offset is the one that sticks.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            end
        end
        if (sum >= (IDX_W + 1)'(N_CH)) begin
            sum = sum - (IDX_W + 1)'(N_CH);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture on N_CH level inputs, shared round-robin onto one valid/ready port.
// Define EDGE_ARB_DROP_CNT_EN to build saturating per-channel drop counters.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         a,
    output logic                    evt_valid,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    input  logic                    evt_ready,
    output logic [N_CH-1:0]         overflow,
    output logic [N_CH*CNT_W-1:0]   drop_cnt
);

    localparam int IDX_W = $clog2(N_CH);

    logic [N_CH-1:0]  a_r;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  pending_nxt;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  granted;
    logic [N_CH-1:0]  drop;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             load;

    edge_arb_rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // A rise on the channel being granted refills pending instead of counting as a drop.
    always_comb begin
        load    = ~evt_valid | evt_ready;
        rise    = a & ~a_r;
        granted = '0;
        if (load && pick_found) begin
            granted[pick_idx] = 1'b1;
        end
        drop        = rise & pending & ~granted;
        pending_nxt = (pending & ~granted) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            rr_ptr    <= '0;
            overflow  <= '0;
        end else begin
            a_r      <= a;
            pending  <= pending_nxt;
            overflow <= overflow | drop;
            if (load) begin
                evt_valid <= pick_found;
                if (pick_found) begin
                    evt_ch <= pick_idx;
                    rr_ptr <= IDX_W'(rr_next(32'(pick_idx), N_CH));
                end
            end
        end
    end

`ifdef EDGE_ARB_DROP_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (drop[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            drop_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: vector table, directed corner sequences, random vs model.
// Counter checks follow EDGE_ARB_DROP_CNT_EN when it is defined for the build.
module tb_edge_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  a = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_ch;
    logic [N-1:0]  overflow;
    logic [N*CW-1:0] drop_cnt;

    edge_event_arbiter #(.N_CH(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel pending flags and a single output slot.
    logic [N-1:0] m_prev;
    bit           m_pend [N];
    bit           m_valid;
    int           m_ch;
    int           m_ptr;
    logic [N-1:0] m_ovf;
    int           m_cnt [N];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rs, input logic [N-1:0] av, input logic rv);
        int g;
        int c;
        bit rose;
        if (rs) begin
            m_prev  = '0;
            m_valid = 0;
            m_ch    = 0;
            m_ptr   = 0;
            m_ovf   = '0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_cnt[i]  = 0;
            end
        end else begin
            g = -1;
            if (!m_valid || rv) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (g < 0 && m_pend[c]) g = c;
                end
                if (g >= 0) begin
                    m_valid = 1;
                    m_ch    = g;
                    m_ptr   = (g + 1) % N;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                rose = av[i] && !m_prev[i];
                if (rose && m_pend[i] && g != i) begin
                    m_ovf[i] = 1'b1;
                    if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
                end
                m_pend[i] = (m_pend[i] && g != i) || rose;
            end
            m_prev = av;
        end
    endtask

    task automatic cyc(input logic rs, input logic [N-1:0] av, input logic rv);
        rst       = rs;
        a         = av;
        evt_ready = rv;
        model_step(rs, av, rv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 4'h0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0);
    endtask

    typedef struct {
        logic       rs;
        logic [3:0] av;
        logic       rdy;
        logic       ev;
        int         ech;
        logic       cch;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic       rs;
        logic [3:0] av;
        logic       rv;

        // single edge on ch0, then all four channels at once
        tbl[0]  = '{1'b1, 4'h0, 1'b1, 1'b0, 0, 1'b1};
        tbl[1]  = '{1'b0, 4'h1, 1'b1, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b0, 4'h1, 1'b1, 1'b1, 0, 1'b1};
        tbl[3]  = '{1'b0, 4'h1, 1'b1, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 4'h0, 1'b1, 1'b0, 0, 1'b1};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 1'b0, 0, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, 1'b1, 0, 1'b1};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1, 1'b1};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2, 1'b1};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 1'b1, 3, 1'b1};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 1'b0, 0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rs, tbl[i].av, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].ev));
            if (tbl[i].cch) chk($sformatf("tbl%0d_ch", i), int'(evt_ch), tbl[i].ech);
            chk($sformatf("tbl%0d_ovf", i), int'(overflow), 0);
        end

        // stall: ch2 then ch1, ch2 held while ready low
        do_reset();
        cyc(1'b0, 4'b0100, 1'b0);
        chk("stall_idle", int'(evt_valid), 0);
        cyc(1'b0, 4'b0110, 1'b0);
        chk("stall_v0", int'(evt_valid), 1);
        chk("stall_ch0", int'(evt_ch), 2);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b0110, 1'b0);
            chk($sformatf("stall_hold_v%0d", k), int'(evt_valid), 1);
            chk($sformatf("stall_hold_ch%0d", k), int'(evt_ch), 2);
        end
        cyc(1'b0, 4'b0110, 1'b1);
        chk("stall_next_v", int'(evt_valid), 1);
        chk("stall_next_ch", int'(evt_ch), 1);
        cyc(1'b0, 4'b0110, 1'b1);
        chk("stall_done_v", int'(evt_valid), 0);
        chk("stall_ovf", int'(overflow), 0);

        // drop on ch3 while output is occupied by ch0
        do_reset();
        cyc(1'b0, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("drop_occ_v", int'(evt_valid), 1);
        chk("drop_occ_ch", int'(evt_ch), 0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("drop_first_ovf", int'(overflow), 0);
        cyc(1'b0, 4'b0001, 1'b0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("drop_ovf", int'(overflow), 8);
`ifdef EDGE_ARB_DROP_CNT_EN
        chk("drop_cnt3_1", int'(drop_cnt[3*CW +: CW]), 1);
`endif
        for (int k = 0; k < 300; k++) begin
            cyc(1'b0, 4'b0001, 1'b0);
            cyc(1'b0, 4'b1001, 1'b0);
        end
        chk("drop_ovf_sticky", int'(overflow), 8);
`ifdef EDGE_ARB_DROP_CNT_EN
        chk("drop_cnt3_sat", int'(drop_cnt[3*CW +: CW]), 255);
        chk("drop_cnt0", int'(drop_cnt[0 +: CW]), 0);
`else
        chk("drop_cnt_tied", int'(drop_cnt), 0);
`endif
        chk("drop_hold_ch", int'(evt_ch), 0);
        cyc(1'b0, 4'b1001, 1'b1);
        chk("drop_rel_v", int'(evt_valid), 1);
        chk("drop_rel_ch", int'(evt_ch), 3);
        cyc(1'b0, 4'b1001, 1'b1);
        chk("drop_rel_end", int'(evt_valid), 0);

        // ch1 re-rises in the cycle it is granted
        do_reset();
        cyc(1'b0, 4'b0011, 1'b1);
        chk("regrant_idle", int'(evt_valid), 0);
        cyc(1'b0, 4'b0001, 1'b1);
        chk("regrant_ch0", int'(evt_ch), 0);
        cyc(1'b0, 4'b0011, 1'b1);
        chk("regrant_v1", int'(evt_valid), 1);
        chk("regrant_ch1a", int'(evt_ch), 1);
        cyc(1'b0, 4'b0011, 1'b1);
        chk("regrant_v2", int'(evt_valid), 1);
        chk("regrant_ch1b", int'(evt_ch), 1);
        cyc(1'b0, 4'b0011, 1'b1);
        chk("regrant_end", int'(evt_valid), 0);
        chk("regrant_ovf", int'(overflow), 0);

        // reset while an event is held and all inputs are high
        do_reset();
        cyc(1'b0, 4'hF, 1'b0);
        cyc(1'b0, 4'hF, 1'b0);
        chk("rst_pre_v", int'(evt_valid), 1);
        cyc(1'b1, 4'hF, 1'b0);
        chk("rst_v", int'(evt_valid), 0);
        chk("rst_ch", int'(evt_ch), 0);
        chk("rst_ovf", int'(overflow), 0);
        cyc(1'b0, 4'hF, 1'b1);
        chk("rst_exit_v", int'(evt_valid), 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'hF, 1'b1);
            chk($sformatf("rst_seq_v%0d", k), int'(evt_valid), 1);
            chk($sformatf("rst_seq_ch%0d", k), int'(evt_ch), k);
        end
        cyc(1'b0, 4'hF, 1'b1);
        chk("rst_seq_end", int'(evt_valid), 0);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 127) == 0);
            av = 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 3) != 0);
            cyc(rs, av, rv);
            chk("rnd_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) chk("rnd_ch", int'(evt_ch), m_ch);
            chk("rnd_ovf", int'(overflow), int'(m_ovf));
`ifdef EDGE_ARB_DROP_CNT_EN
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rnd_cnt%0d", i), int'(drop_cnt[i*CW +: CW]), m_cnt[i]);
            end
`endif
        end
`ifndef EDGE_ARB_DROP_CNT_EN
        chk("rnd_cnt_tied", int'(drop_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
